// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and helpers for the Wishbone register-bus arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, BUSY, ERR)
//   DEF_AWIDTH/DWIDTH : default bus widths of the usbHostSlave register bus
//   grant_idx_width() : width of a grant index for a given master count
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_t;

    localparam int DEF_AWIDTH = 9;
    localparam int DEF_DWIDTH = 8;

    function automatic int grant_idx_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_arb_rr_pick
// Combinational round-robin picker. Searches upward from last_grant+1 with
// wrap-around and returns the first requester as a one-hot winner.
//   req        : request vector, one bit per master
//   last_grant : index of the most recently granted master
//   winner     : one-hot winner (all zero when nobody requests)
//   valid      : at least one master is requesting
// -----------------------------------------------------------------------------
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IW          = grant_idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last_grant,
    output logic [NUM_MASTERS-1:0] winner,
    output logic                   valid
);

    // NOTE: every variable written here gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        int          idx;
        logic [IW-1:0] sel;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            sel = IW'(idx);
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Round-robin Wishbone arbiter sharing the host/slave register bus of the
// usbHostSlave instances. The grant is held for the winner's whole cyc, so
// multi-access register sequences are atomic. adr[AWIDTH-1] selects host (0)
// or slave (1).
//   clk_i, rst_i              : bus clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i    : per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i           : packed per-master address / write data
//   m_dat_o                   : read data broadcast to all masters
//   m_ack_o/m_err_o           : per-master ack / timeout error pulse
//   s_adr_o/s_dat_o/s_we_o    : forwarded device-local address, data, we
//   s_host_stb_o/s_slave_stb_o: decoded device strobes
//   s_host_dat_i/s_slave_dat_i: device read data
//   s_ack_i                   : ORed device ack
//   grant_o                   : registered one-hot grant (debug)
// Optional feature macro: WB_ARB_TIMEOUT_EN enables the strobe-without-ack
// timeout (ERR state, m_err_o pulse). Without it m_err_o is tied to 0.
// -----------------------------------------------------------------------------
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AWIDTH         = DEF_AWIDTH,
    parameter int DWIDTH         = DEF_DWIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*AWIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DWIDTH-1:0] m_dat_i,
    output logic [DWIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [AWIDTH-2:0]             s_adr_o,
    output logic [DWIDTH-1:0]             s_dat_o,
    output logic                          s_we_o,
    output logic                          s_host_stb_o,
    output logic                          s_slave_stb_o,
    input  logic [DWIDTH-1:0]             s_host_dat_i,
    input  logic [DWIDTH-1:0]             s_slave_dat_i,
    input  logic                          s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int            IW         = grant_idx_width(NUM_MASTERS);
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_MASTERS - 1);

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
    logic [IW-1:0]          last_q, last_nxt;   // also the current grant index while BUSY
    logic [NUM_MASTERS-1:0] req, win;
    logic                   win_valid;
    logic [IW-1:0]          win_idx;
    logic                   to_hit;

    assign req = m_cyc_i & m_stb_i;

    wb_arb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req        (req),
        .last_grant (last_q),
        .winner     (win),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (win[k]) win_idx = IW'(k);
    end

    // Unpack the per-master buses so the granted master is a simple array select.
    logic [AWIDTH-1:0] adr_arr [NUM_MASTERS];
    logic [DWIDTH-1:0] dat_arr [NUM_MASTERS];
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign adr_arr[k] = m_adr_i[k*AWIDTH +: AWIDTH];
        assign dat_arr[k] = m_dat_i[k*DWIDTH +: DWIDTH];
    end

    logic              sel_cyc, sel_stb, sel_we;
    logic [AWIDTH-1:0] sel_adr;
    logic [DWIDTH-1:0] sel_dat;
    assign sel_cyc = m_cyc_i[last_q];
    assign sel_stb = m_stb_i[last_q];
    assign sel_we  = m_we_i[last_q];
    assign sel_adr = adr_arr[last_q];
    assign sel_dat = dat_arr[last_q];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RESET;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
        end
    end

    // Arbitration happens only in IDLE, so a request arriving in the holder's
    // release cycle is served one IDLE cycle later.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = BUSY;
                    grant_nxt = win;
                    last_nxt  = win_idx;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (to_hit) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Slave side is quiet outside BUSY; this also forces strobes low in ERR.
    always_comb begin
        s_adr_o       = '0;
        s_dat_o       = '0;
        s_we_o        = 1'b0;
        s_host_stb_o  = 1'b0;
        s_slave_stb_o = 1'b0;
        m_dat_o       = '0;
        m_ack_o       = '0;
        if (state == BUSY) begin
            s_adr_o       = sel_adr[AWIDTH-2:0];
            s_dat_o       = sel_dat;
            s_we_o        = sel_we;
            s_host_stb_o  = sel_stb & ~sel_adr[AWIDTH-1];
            s_slave_stb_o = sel_stb &  sel_adr[AWIDTH-1];
            m_dat_o       = sel_adr[AWIDTH-1] ? s_slave_dat_i : s_host_dat_i;
            if (s_ack_i && sel_stb) m_ack_o = grant_q;
        end
    end

    assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    // Counts strobed-but-unacked BUSY cycles; holds during stb gaps.
    logic [7:0] to_cnt;

    assign to_hit = sel_stb && !s_ack_i && ((to_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                          to_cnt <= '0;
        else if (state != BUSY || s_ack_i)   to_cnt <= '0;
        else if (sel_stb)                    to_cnt <= to_cnt + 8'd1;
    end

    assign m_err_o = (state == ERR) ? grant_q : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT_CYCLES);
    assign to_hit         = 1'b0;
    assign m_err_o        = '0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Self-checking bench for wb_bus_arbiter with three masters. A behavioural
// model (owner index, last winner, wait counter) predicts every output after
// each clock edge. The device side is a bench model: read data is a fixed
// function of the address and ack is combinational from the strobes.
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0] cyc, stb, we;
    logic [AW-1:0] adr  [NM];
    logic [DW-1:0] wdat [NM];
    logic          ack_en, force_ack;

    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
    logic [AW-2:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o, s_host_dat_i, s_slave_dat_i;
    logic             s_we_o, s_host_stb_o, s_slave_stb_o, s_ack_i;

    function automatic logic [7:0] host_f(input logic [7:0] a);
        return a ^ 8'hA0;
    endfunction
    function automatic logic [7:0] slave_f(input logic [7:0] a);
        return a + 8'h31;
    endfunction

    assign m_adr_i       = {adr[2], adr[1], adr[0]};
    assign m_dat_i       = {wdat[2], wdat[1], wdat[0]};
    assign s_host_dat_i  = host_f(s_adr_o);
    assign s_slave_dat_i = slave_f(s_adr_o);
    assign s_ack_i       = force_ack | (ack_en & (s_host_stb_o | s_slave_stb_o));

    wb_bus_arbiter #(
        .NUM_MASTERS(NM), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_host_stb_o(s_host_stb_o), .s_slave_stb_o(s_slave_stb_o),
        .s_host_dat_i(s_host_dat_i), .s_slave_dat_i(s_slave_dat_i),
        .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int owner;     // granted master, -1 when nobody holds the bus
    int last;      // most recent winner
    int wait_cnt;  // strobed cycles without ack for the current owner
    bit in_err;    // owner is being aborted this cycle

    task automatic model_reset();
        owner    = -1;
        last     = NM - 1;
        wait_cnt = 0;
        in_err   = 0;
    endtask

    function automatic bit model_busy();
        return (owner >= 0) && !in_err;
    endfunction

    function automatic bit model_stb();
        return model_busy() ? bit'(stb[owner]) : 1'b0;
    endfunction

    task automatic model_edge();
        bit ack_in, found;
        int k;
        ack_in = force_ack || (ack_en && model_stb());
        found  = 0;
        if (in_err) begin
            in_err   = 0;
            owner    = -1;
            wait_cnt = 0;
        end else if (owner < 0) begin
            wait_cnt = 0;
            for (int i = 1; i <= NM; i++) begin
                k = (last + i) % NM;
                if (!found && cyc[k] && stb[k]) begin
                    found = 1;
                    owner = k;
                    last  = k;
                end
            end
        end else if (!cyc[owner]) begin
            owner    = -1;
            wait_cnt = 0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (ack_in) begin
            wait_cnt = 0;
        end else if (stb[owner]) begin
            wait_cnt++;
            if (wait_cnt == TO) begin
                in_err   = 1;
                wait_cnt = 0;
            end
        end
`endif
    endtask

    task automatic check_outputs(input string ctx);
        logic [NM-1:0] g;
        logic [AW-1:0] a;
        bit            busy, s, ack_in;
        logic [7:0]    rd;
        busy   = model_busy();
        s      = model_stb();
        g      = (owner >= 0) ? (NM'(1) << owner) : '0;
        a      = (owner >= 0) ? adr[owner] : '0;
        ack_in = force_ack || (ack_en && s);
        rd     = a[AW-1] ? slave_f(a[7:0]) : host_f(a[7:0]);
        check({ctx, ".grant"},     32'(grant_o),       32'(g));
        check({ctx, ".host_stb"},  32'(s_host_stb_o),  32'(s && !a[AW-1]));
        check({ctx, ".slave_stb"}, 32'(s_slave_stb_o), 32'(s && a[AW-1]));
        check({ctx, ".s_adr"},     32'(s_adr_o),       busy ? 32'(a[AW-2:0]) : 32'd0);
        check({ctx, ".s_dat"},     32'(s_dat_o),       busy ? 32'(wdat[owner]) : 32'd0);
        check({ctx, ".s_we"},      32'(s_we_o),        busy ? 32'(we[owner]) : 32'd0);
        check({ctx, ".m_dat"},     32'(m_dat_o),       busy ? 32'(rd) : 32'd0);
        check({ctx, ".m_ack"},     32'(m_ack_o),       (s && ack_in) ? 32'(g) : 32'd0);
        check({ctx, ".m_err"},     32'(m_err_o),       in_err ? 32'(g) : 32'd0);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ctx);
    endtask

    // Asserts reset 3 time units after the last edge (mid-cycle), checks the
    // immediate effect, and releases on the following falling edge.
    task automatic apply_reset(input string ctx);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs(ctx);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        cyc = '0; stb = '0; we = '0; ack_en = 1'b0; force_ack = 1'b0;
        for (int i = 0; i < NM; i++) begin
            adr[i]  = '0;
            wdat[i] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, err_at, err_len;
        idle_inputs();
        model_reset();

        // Reset values
        #1 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single master 0 writes 0x5A to slave register 0x105
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 9'h105; wdat[0] = 8'h5A;
        step("wr_grant");
        check("wr.slave_stb", 32'(s_slave_stb_o), 32'd1);
        check("wr.host_stb",  32'(s_host_stb_o),  32'd0);
        check("wr.s_adr",     32'(s_adr_o),       32'h05);
        check("wr.s_dat",     32'(s_dat_o),       32'h5A);
        ack_en = 1;
        #1 check("wr.ack", 32'(m_ack_o), 32'b001);
        check_outputs("wr_ack");
        step("wr_acked");
        cyc[0] = 0; stb[0] = 0; ack_en = 0;
        step("wr_release");

        // Masters 0 and 1 request together after reset
        apply_reset("reset2");
        cyc[1:0] = 2'b11; stb[1:0] = 2'b11; adr[1] = 9'h003;
        step("pair_g0");
        check("pair.first", 32'(grant_o), 32'b001);
        step("pair_hold");
        cyc[0] = 0; stb[0] = 0;
        step("pair_rel0");
        check("pair.idle_gap", 32'(grant_o), 32'b000);
        step("pair_g1");
        check("pair.second", 32'(grant_o), 32'b010);

        // Master 1 locks the bus for three host reads while master 0 waits
        cyc[0] = 1; stb[0] = 1; adr[0] = 9'h1F0;
        for (int i = 0; i < 3; i++) begin
            adr[1] = AW'(i); we[1] = 0; stb[1] = 1; ack_en = 1;
            #1 check("lock.m_dat", 32'(m_dat_o), 32'(host_f(8'(i))));
            check("lock.ack", 32'(m_ack_o), 32'b010);
            step("lock_rd");
            stb[1] = 0; ack_en = 0;
            step("lock_gap");
            check("lock.held", 32'(grant_o), 32'b010);
        end
        cyc[1] = 0;
        step("lock_rel");
        step("lock_next");
        check("lock.m0_after", 32'(grant_o), 32'b001);

        // Ack while idle is ignored
        idle_inputs();
        step("idle_prep");
        force_ack = 1;
        step("idle_ack");
        check("idle.ack", 32'(m_ack_o), 32'd0);
        force_ack = 0;

        // Fairness: all masters keep requesting; each grant holder releases once served
        apply_reset("reset3");
        cyc = '1; stb = '1; ack_en = 1;
        for (int i = 0; i < NM; i++) adr[i] = AW'(9'h040 + i);
        for (int n = 0; n < 9; n++) begin
            got = 0;
            for (int w = 0; w < 4 && got == 0; w++) begin
                step("fair");
                if (grant_o != '0) got = 1;
            end
            check("fair.seq", 32'(grant_o), 32'(NM'(1) << (n % NM)));
            if (owner >= 0) begin
                cyc[owner] = 0; stb[owner] = 0;
            end
            step("fair_rel");
            cyc = '1; stb = '1;
        end

        // Device never acks
        idle_inputs();
        apply_reset("reset4");
        cyc[2] = 1; stb[2] = 1; adr[2] = 9'h010;
        step("to_grant");
        err_at = 0; err_len = 0;
        for (int c = 1; c <= 20; c++) begin
            step("to_wait");
            if (m_err_o != '0) begin
                err_len++;
                if (err_at == 0) err_at = c;
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("to.err_at",  32'(err_at),  32'(TO));
        check("to.err_len", 32'(err_len), 32'd1);
`else
        check("to.no_err",  32'(err_len), 32'd0);
`endif
        idle_inputs();
        step("to_drop");
        step("to_idle");

        // Reset during a granted write
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 9'h0AB; wdat[1] = 8'hC3;
        got = 0;
        for (int w = 0; w < 4 && got == 0; w++) begin
            step("rst_wr");
            if (grant_o != '0) got = 1;
        end
        check("rstwr.granted", 32'(grant_o), 32'b010);
        apply_reset("rst_mid");
        check("rstwr.we_zero", 32'(s_we_o), 32'd0);
        cyc[0] = 1; stb[0] = 1;
        step("rst_after");
        check("rstwr.m0_wins", 32'(grant_o), 32'b001);

        // Randomised traffic against the model
        idle_inputs();
        step("rand_start");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 7) == 0) cyc[i] = ~cyc[i];
                stb[i]  = cyc[i] & 1'($urandom_range(0, 3) != 0);
                we[i]   = 1'($urandom);
                adr[i]  = AW'($urandom);
                wdat[i] = DW'($urandom);
            end
            ack_en    = 1'($urandom_range(0, 3) != 0);
            force_ack = 1'($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin Wishbone arbiter that shares the 9-bit-address, 8-bit-data register bus of the host and slave `usbHostSlave` instances among several bus masters. Typical masters are a CPU, a USB transaction sequencer and a bench model. The arbiter grants one master at a time and holds the grant for the master's whole `cyc` cycle, so multi-access register sequences are atomic. It decodes `adr[8]` into separate host and slave strobes and returns read data and acks to the granted master only.

## Interface
- `NUM_MASTERS`, 2 — number of requesters, 2..4.
- `AWIDTH`, 9 — address width; bit `AWIDTH-1` selects the device (0 = host, 1 = slave).
- `DWIDTH`, 8 — data width.
- `TIMEOUT_CYCLES`, 255 — strobe-without-ack limit; used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1 — bus clock.
- `rst_i` in 1 — asynchronous, active-low reset.
- `m_cyc_i` in NUM_MASTERS — per-master cycle request.
- `m_stb_i` in NUM_MASTERS — per-master strobe.
- `m_we_i` in NUM_MASTERS — per-master write enable.
- `m_adr_i` in NUM_MASTERS*AWIDTH — packed addresses; master k occupies `[k*AWIDTH +: AWIDTH]`.
- `m_dat_i` in NUM_MASTERS*DWIDTH — packed write data.
- `m_dat_o` out DWIDTH — read data, broadcast to all masters.
- `m_ack_o` out NUM_MASTERS — ack, asserted to the granted master only.
- `m_err_o` out NUM_MASTERS — timeout error pulse.
- `s_adr_o` out AWIDTH-1 — device-local address.
- `s_dat_o` out DWIDTH — write data.
- `s_we_o` out 1 — write enable.
- `s_host_stb_o` out 1 — host strobe.
- `s_slave_stb_o` out 1 — slave strobe.
- `s_host_dat_i` in DWIDTH — host read data.
- `s_slave_dat_i` in DWIDTH — slave read data.
- `s_ack_i` in 1 — ORed ack from both devices.
- `grant_o` out NUM_MASTERS — one-hot grant, for debug.

## Operation
- States:
  - IDLE: no grant; all slave-side outputs 0.
  - BUSY: one master granted; its signals are forwarded.
  - ERR: timeout abort, only with `WB_ARB_TIMEOUT_EN`.
- A master is requesting when `m_cyc_i[k] & m_stb_i[k]`.
- IDLE → BUSY: on any request. Winner is the first requester searching upward, with wrap-around, from `last_grant+1`. `grant_o` and `last_grant` are registered.
- BUSY forwarding (combinational from the granted master):
  - `s_we_o`, `s_dat_o`, `s_adr_o = adr[AWIDTH-2:0]`.
  - `s_host_stb_o = stb & ~adr[AWIDTH-1]`, `s_slave_stb_o = stb & adr[AWIDTH-1]`.
  - `m_dat_o` = slave data when `adr[AWIDTH-1]` is 1, else host data.
  - `m_ack_o[g] = s_ack_i & stb`.
- BUSY → IDLE: when `m_cyc_i[g]` drops. The grant is held across gaps in `stb` while `cyc` stays high (locked sequence).
- Non-granted masters see `ack = 0` and `err = 0` and simply wait.
- A request and the grant holder's `cyc` release in the same cycle: the request is served in the next arbitration, never in the release cycle.
- `s_ack_i` seen while in IDLE is ignored.
- Reset mid-cycle: the FSM goes to IDLE immediately, all outputs return to 0, and `last_grant` returns to `NUM_MASTERS-1`.

## Timing
- Reset values: every output is 0; `last_grant = NUM_MASTERS-1`, so master 0 wins the first contest.
- Arbitration latency: a request seen in IDLE at edge N yields grant and slave strobe in the cycle after edge N. First access latency = 1 cycle plus device ack latency.
- Ack path: zero-cycle pass-through.
- Gap between grants: exactly 1 IDLE cycle between `cyc` release and the next grant.
- Fairness: with all masters requesting continuously, each master receives one grant per NUM_MASTERS grants.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUSY cycle in which `stb` is high and `s_ack_i` is low, and clears on ack.
  - When it reaches `TIMEOUT_CYCLES`: go to ERR, pulse `m_err_o[g]` for 1 cycle, force both slave strobes low, then go to IDLE. The grant is dropped even if `cyc` is still high.
- `WB_ARB_TIMEOUT_EN` undefined: no counter, no ERR state, `m_err_o` tied to 0, and a missing ack hangs the bus.

## Structure
- Package `wb_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY, ERR);
  - default `AWIDTH`/`DWIDTH` localparams;
  - the grant-index width function (`$clog2(NUM_MASTERS)`).
- Sub-module `wb_arb_rr_pick`: purely combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are a one-hot winner and a valid flag.
- The top level holds the FSM, grant registers, forwarding muxes and the timeout counter.

## Test plan
- Single master 0 writes 0x5A to adr 0x105 → `s_slave_stb_o = 1`, `s_adr_o = 0x05`, `s_dat_o = 0x5A`; `m_ack_o = 2'b01` on the device ack; `s_host_stb_o` stays 0.
- Masters 0 and 1 request in the same cycle after reset → master 0 granted first; master 1 granted exactly 1 IDLE cycle after master 0 drops `cyc`.
- Master 1 holds `cyc` across three reads of 0x000..0x002 while master 0 requests → master 0 is not granted until master 1 releases; `m_dat_o` equals host data each ack.
- NUM_MASTERS = 3, all requesting continuously for 9 grants → grant sequence 0,1,2,0,1,2,0,1,2.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES = 16`, device never acks → `m_err_o[g]` pulses for 1 cycle 16 cycles after the strobe; strobes drop; FSM returns to IDLE.
- `rst_i` driven low during a granted write → all outputs are 0 in the same cycle; after release, master 0 wins the next contest.
